// File: rtl/wb_mem_arbiter.sv
// Round-robin three-master Wishbone B3 arbiter in front of the main-RAM slave port.
// Optional stalled-access watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_mem_arbiter #(
    parameter int NM      = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NM*AW-1:0]     wbm_adr_i,
    input  logic [NM*DW-1:0]     wbm_dat_i,
    input  logic [NM*DW/8-1:0]   wbm_sel_i,
    input  logic [NM-1:0]        wbm_we_i,
    input  logic [NM-1:0]        wbm_cyc_i,
    input  logic [NM-1:0]        wbm_stb_i,
    input  logic [NM*3-1:0]      wbm_cti_i,
    input  logic [NM*2-1:0]      wbm_bte_i,
    output logic [DW-1:0]        wbm_dat_o,
    output logic [NM-1:0]        wbm_ack_o,
    output logic [NM-1:0]        wbm_err_o,
    output logic [NM-1:0]        wbm_rty_o,
    output logic [AW-1:0]        wbs_adr_o,
    output logic [DW-1:0]        wbs_dat_o,
    output logic [DW/8-1:0]      wbs_sel_o,
    output logic                 wbs_we_o,
    output logic                 wbs_cyc_o,
    output logic                 wbs_stb_o,
    output logic [2:0]           wbs_cti_o,
    output logic [1:0]           wbs_bte_o,
    input  logic [DW-1:0]        wbs_dat_i,
    input  logic                 wbs_ack_i,
    input  logic                 wbs_err_i,
    input  logic                 wbs_rty_i,
    output logic [NM-1:0]        grant_o
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [GW-1:0]   g;
    logic [GW-1:0]   last;
    logic [GW-1:0]   nxt;
    logic [GW-1:0]   idx;
    logic            found;
    logic            tmo;

    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [DW/8-1:0] own_sel;
    logic            own_we;
    logic            own_cyc;
    logic            own_stb;
    logic [2:0]      own_cti;
    logic [1:0]      own_bte;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        nxt   = last;
        idx   = '0;
        for (int i = 1; i <= NM; i++) begin
            idx = GW'((int'(last) + i) % NM);
            if (!found && wbm_cyc_i[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
    end

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = '0;
        own_bte = '0;
        for (int k = 0; k < NM; k++) begin
            if (g == GW'(k)) begin
                own_adr = wbm_adr_i[k*AW +: AW];
                own_dat = wbm_dat_i[k*DW +: DW];
                own_sel = wbm_sel_i[k*(DW/8) +: DW/8];
                own_we  = wbm_we_i[k];
                own_cyc = wbm_cyc_i[k];
                own_stb = wbm_stb_i[k];
                own_cti = wbm_cti_i[k*3 +: 3];
                own_bte = wbm_bte_i[k*2 +: 2];
            end
        end
    end

    // No direct handover: an owner always returns to IDLE before the next grant.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            g       <= '0;
            last    <= GW'(NM - 1);
            grant_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= BUSY;
                        g       <= nxt;
                        last    <= nxt;
                        grant_o <= NM'(1) << nxt;
                    end
                end
                BUSY: begin
                    if (!wbm_cyc_i[g]) begin
                        state   <= IDLE;
                        grant_o <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        term;

    assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign tmo  = (state == BUSY) && (wd_cnt == 16'(TIMEOUT));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt <= '0;
        end else if (state != BUSY || tmo || term || !wbm_cyc_i[g]) begin
            wd_cnt <= '0;
        end else if (own_stb) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT);
    assign tmo            = 1'b0;
`endif

    // A timeout masks the slave's ack and turns the access into an error.
    always_comb begin
        wbm_dat_o = wbs_dat_i;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (state == BUSY) begin
            wbs_adr_o    = own_adr;
            wbs_dat_o    = own_dat;
            wbs_sel_o    = own_sel;
            wbs_we_o     = own_we;
            wbs_cyc_o    = own_cyc & ~tmo;
            wbs_stb_o    = own_stb & ~tmo;
            wbs_cti_o    = own_cti;
            wbs_bte_o    = own_bte;
            wbm_ack_o[g] = wbs_ack_i & ~tmo;
            wbm_err_o[g] = wbs_err_i | tmo;
            wbm_rty_o[g] = wbs_rty_i & ~tmo;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: cycle-vector table plus hand sequences for
// single-master read, mid-burst reset and the watchdog (macro on or off).
module tb_wb_mem_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*AW-1:0]  wbm_adr;
    logic [NM*DW-1:0]  wbm_dat;
    logic [NM*DW/8-1:0] wbm_sel;
    logic [NM-1:0]     wbm_we;
    logic [NM-1:0]     wbm_cyc;
    logic [NM-1:0]     wbm_stb;
    logic [NM*3-1:0]   wbm_cti;
    logic [NM*2-1:0]   wbm_bte;
    logic [DW-1:0]     wbm_dat_o;
    logic [NM-1:0]     wbm_ack_o;
    logic [NM-1:0]     wbm_err_o;
    logic [NM-1:0]     wbm_rty_o;
    logic [AW-1:0]     wbs_adr;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel;
    logic              wbs_we;
    logic              wbs_cyc;
    logic              wbs_stb;
    logic [2:0]        wbs_cti;
    logic [1:0]        wbs_bte;
    logic [DW-1:0]     wbs_dat_i;
    logic              wbs_ack;
    logic              wbs_err;
    logic              wbs_rty;
    logic [NM-1:0]     grant;

    int checks = 0;
    int errors = 0;

    logic [31:0] adr_tab [3];

    wb_mem_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbm_adr_i(wbm_adr),
        .wbm_dat_i(wbm_dat),
        .wbm_sel_i(wbm_sel),
        .wbm_we_i (wbm_we),
        .wbm_cyc_i(wbm_cyc),
        .wbm_stb_i(wbm_stb),
        .wbm_cti_i(wbm_cti),
        .wbm_bte_i(wbm_bte),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr),
        .wbs_dat_o(wbs_dat_o),
        .wbs_sel_o(wbs_sel),
        .wbs_we_o (wbs_we),
        .wbs_cyc_o(wbs_cyc),
        .wbs_stb_o(wbs_stb),
        .wbs_cti_o(wbs_cti),
        .wbs_bte_o(wbs_bte),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack),
        .wbs_err_i(wbs_err),
        .wbs_rty_i(wbs_rty),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [2:0] cyc;
        logic [2:0] stb;
        logic [2:0] cti1;
        logic       ack;
        logic       err;
        logic [2:0] e_grant;
        logic       e_scyc;
        logic       e_sstb;
        logic [2:0] e_ack;
        logic [2:0] e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic r, logic [2:0] c, logic [2:0] s,
                                logic [2:0] ct, logic a, logic e, logic [2:0] eg,
                                logic ec, logic es, logic [2:0] ea, logic [2:0] ee);
        vec_t v;
        v.name = nm; v.rst_n = r; v.cyc = c; v.stb = s; v.cti1 = ct;
        v.ack = a; v.err = e; v.e_grant = eg; v.e_scyc = ec; v.e_sstb = es;
        v.e_ack = ea; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [2:0] s, input logic [2:0] ct1,
                         input logic a, input logic e);
        wbm_cyc = c;
        wbm_stb = s;
        wbm_cti = {3'b000, ct1, 3'b000};
        wbs_ack = a;
        wbs_err = e;
    endtask

    initial begin
        logic [31:0] e_adr;
        logic [2:0]  e_cti;

        adr_tab[0] = 32'h0000_0010;
        adr_tab[1] = 32'h0000_0040;
        adr_tab[2] = 32'h0000_0100;
        rst_n     = 1'b0;
        wbm_adr   = {adr_tab[2], adr_tab[1], adr_tab[0]};
        wbm_dat   = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        wbm_sel   = '1;
        wbm_we    = 3'b001;
        wbm_bte   = '0;
        wbs_dat_i = 32'h0;
        wbs_rty   = 1'b0;
        drive(3'b111, 3'b111, 3'b000, 1'b1, 1'b0);

        //            name           rst cyc     stb     cti1    ack  err   grant   scyc stb  ack     err
        vecs.push_back(mk("rst_hold0",   0, 3'b111, 3'b111, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rst_hold1",   0, 3'b111, 3'b111, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rst_release", 1, 3'b111, 3'b111, 3'b000, 1, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_m0",       1, 3'b111, 3'b111, 3'b000, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000));
        vecs.push_back(mk("rr_m0_drop",  1, 3'b110, 3'b110, 3'b000, 0, 0, 3'b001, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_idle_a",   1, 3'b111, 3'b111, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_m1",       1, 3'b111, 3'b111, 3'b000, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000));
        vecs.push_back(mk("rr_m1_drop",  1, 3'b101, 3'b101, 3'b000, 0, 0, 3'b010, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_idle_b",   1, 3'b111, 3'b111, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_m2",       1, 3'b111, 3'b111, 3'b000, 1, 0, 3'b100, 1, 1, 3'b100, 3'b000));
        vecs.push_back(mk("rr_m2_drop",  1, 3'b011, 3'b011, 3'b000, 0, 0, 3'b100, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_idle_c",   1, 3'b011, 3'b011, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("rr_m0_err",   1, 3'b011, 3'b011, 3'b000, 0, 1, 3'b001, 1, 1, 3'b000, 3'b001));
        vecs.push_back(mk("rr_m0_drop2", 1, 3'b010, 3'b010, 3'b000, 0, 0, 3'b001, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("bl_idle",     1, 3'b011, 3'b011, 3'b010, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("bl_beat1",    1, 3'b011, 3'b011, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000));
        vecs.push_back(mk("bl_gap",      1, 3'b011, 3'b001, 3'b010, 0, 0, 3'b010, 1, 0, 3'b000, 3'b000));
        vecs.push_back(mk("bl_beat2",    1, 3'b011, 3'b011, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000));
        vecs.push_back(mk("bl_beat3",    1, 3'b011, 3'b011, 3'b010, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000));
        vecs.push_back(mk("bl_beat4",    1, 3'b011, 3'b011, 3'b111, 1, 0, 3'b010, 1, 1, 3'b010, 3'b000));
        vecs.push_back(mk("bl_drop",     1, 3'b001, 3'b001, 3'b000, 0, 0, 3'b010, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("bl_idle2",    1, 3'b001, 3'b001, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("bl_m0",       1, 3'b001, 3'b001, 3'b000, 1, 0, 3'b001, 1, 1, 3'b001, 3'b000));
        vecs.push_back(mk("end_drop",    1, 3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk("end_idle",    1, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));

        foreach (vecs[i]) begin
            tick();
            rst_n = vecs[i].rst_n;
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].cti1, vecs[i].ack, vecs[i].err);
            #3;
            chk({vecs[i].name, ".grant"}, 32'(grant), 32'(vecs[i].e_grant));
            chk({vecs[i].name, ".scyc"}, 32'(wbs_cyc), 32'(vecs[i].e_scyc));
            chk({vecs[i].name, ".sstb"}, 32'(wbs_stb), 32'(vecs[i].e_sstb));
            chk({vecs[i].name, ".ack"}, 32'(wbm_ack_o), 32'(vecs[i].e_ack));
            chk({vecs[i].name, ".err"}, 32'(wbm_err_o), 32'(vecs[i].e_err));
            chk({vecs[i].name, ".rty"}, 32'(wbm_rty_o), 32'h0);
            e_adr = 32'h0;
            e_cti = 3'b000;
            case (vecs[i].e_grant)
                3'b001: e_adr = adr_tab[0];
                3'b010: begin e_adr = adr_tab[1]; e_cti = vecs[i].cti1; end
                3'b100: e_adr = adr_tab[2];
                default: e_adr = 32'h0;
            endcase
            chk({vecs[i].name, ".adr"}, wbs_adr, e_adr);
            chk({vecs[i].name, ".cti"}, 32'(wbs_cti), 32'(e_cti));
        end

        // Single master 2 read with data returned through the broadcast bus.
        tick();
        drive(3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
        wbs_dat_i = 32'hDEAD_BEEF;
        #3;
        chk("sm_wait.grant", 32'(grant), 32'h0);
        tick();
        wbs_ack = 1'b1;
        #3;
        chk("sm_grant", 32'(grant), 32'h4);
        chk("sm_adr", wbs_adr, 32'h100);
        chk("sm_we", 32'(wbs_we), 32'h0);
        chk("sm_ack", 32'(wbm_ack_o), 32'h4);
        chk("sm_dat", wbm_dat_o, 32'hDEAD_BEEF);
        tick();
        drive(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        #3;
        chk("sm_drop.grant", 32'(grant), 32'h4);
        chk("sm_drop.scyc", 32'(wbs_cyc), 32'h0);
        tick();
        #3;
        chk("sm_release.grant", 32'(grant), 32'h0);

        // Mid-burst asynchronous reset; master 0 must win afterwards.
        tick();
        drive(3'b010, 3'b010, 3'b010, 1'b0, 1'b0);
        #3;
        chk("mbr_idle.grant", 32'(grant), 32'h0);
        tick();
        wbs_ack = 1'b1;
        #3;
        chk("mbr_beat1.grant", 32'(grant), 32'h2);
        chk("mbr_beat1.ack", 32'(wbm_ack_o), 32'h2);
        tick();
        drive(3'b011, 3'b011, 3'b010, 1'b1, 1'b0);
        #1;
        chk("mbr_beat2.scyc", 32'(wbs_cyc), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mbr_rst.scyc", 32'(wbs_cyc), 32'h0);
        chk("mbr_rst.grant", 32'(grant), 32'h0);
        chk("mbr_rst.ack", 32'(wbm_ack_o), 32'h0);
        chk("mbr_rst.adr", wbs_adr, 32'h0);
        tick();
        rst_n = 1'b1;
        #3;
        chk("mbr_release.grant", 32'(grant), 32'h0);
        tick();
        #3;
        chk("mbr_m0_first", 32'(grant), 32'h1);
        tick();
        drive(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        #3;
        chk("mbr_end.grant", 32'(grant), 32'h0);

        // Slave never terminates; master 1 owns the bus for 13 cycles.
        tick();
        drive(3'b010, 3'b010, 3'b000, 1'b0, 1'b0);
        #3;
        chk("wd_idle.grant", 32'(grant), 32'h0);
        for (int k = 0; k < 13; k++) begin
            tick();
            #3;
`ifdef WB_ARB_WATCHDOG_EN
            chk($sformatf("wd_c%0d.err", k), 32'(wbm_err_o), (k == 8) ? 32'h2 : 32'h0);
            chk($sformatf("wd_c%0d.scyc", k), 32'(wbs_cyc), (k == 8) ? 32'h0 : 32'h1);
            chk($sformatf("wd_c%0d.ack", k), 32'(wbm_ack_o), 32'h0);
`else
            chk($sformatf("wd_c%0d.err", k), 32'(wbm_err_o), 32'h0);
            chk($sformatf("wd_c%0d.scyc", k), 32'(wbs_cyc), 32'h1);
`endif
            chk($sformatf("wd_c%0d.grant", k), 32'(grant), 32'h2);
        end
        tick();
        drive(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        #3;
        chk("wd_end.grant", 32'(grant), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Three-master Wishbone B3 arbiter that sits directly upstream of the main-RAM slave port. It merges the CPU instruction bus, the CPU data bus and the debug-interface master onto a single slave port. Ownership is granted round-robin and held for the whole of a `cyc` (classic or burst). An optional watchdog aborts slave accesses that never terminate.

## Interface
Parameters:
- `NM`, 3: number of masters. Index 0 is `or1k_i`, 1 is `or1k_d`, 2 is `dbg`.
- `AW`, 32: address width.
- `DW`, 32: data width. `sel` width is `DW/8`.
- `TIMEOUT`, 255: watchdog limit in stalled cycles, 1..65535. Only used with `WB_ARB_WATCHDOG_EN`.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `wbm_adr_i` in `NM*AW`: master addresses, packed; master k occupies `[k*AW +: AW]`.
- `wbm_dat_i` in `NM*DW`: master write data.
- `wbm_sel_i` in `NM*DW/8`: master byte selects.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in `NM`: per-master controls.
- `wbm_cti_i` in `NM*3`, `wbm_bte_i` in `NM*2`: burst tags.
- `wbm_dat_o` out `DW`: read data, broadcast to all masters.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out `NM`: per-master terminations.
- `wbs_adr_o` out `AW`, `wbs_dat_o` out `DW`, `wbs_sel_o` out `DW/8`: slave-side address, data, selects.
- `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o` out 1: slave-side controls.
- `wbs_cti_o` out 3, `wbs_bte_o` out 2: slave-side burst tags.
- `wbs_dat_i` in `DW`; `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1: slave responses.
- `grant_o` out `NM`: one-hot current owner; all zeros when idle.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: owner index `g`.
- `last`: registered index of the most recent owner. Reset value is `NM-1`, so master 0 wins first.
- IDLE with any `wbm_cyc_i` high: at the next edge, grant the first requester searching `last+1, last+2, … mod NM`. Then set `g` and `last` to that index and enter BUSY.
- IDLE with no request: stay in IDLE.
- BUSY, combinational routing:
  - All `wbs_*_o` are copied from master `g`.
  - `wbm_ack_o[g]`, `wbm_err_o[g]` and `wbm_rty_o[g]` are copied from the slave.
  - All other masters' terminations are 0.
  - `wbm_dat_o` is `wbs_dat_i` at all times.
- BUSY exit: when `wbm_cyc_i[g]` is sampled low, go to IDLE. There is no direct handover, so a new owner always follows at least one IDLE cycle.
- Non-owners with `cyc` high simply wait; they see no ack, err or rty.
- IDLE outputs: every `wbs_*_o` is 0 and every `wbm_ack/err/rty_o` is 0.
- `stb` low while `cyc` stays high (burst gap or wait): the owner keeps the grant.
- Reset: asserting `wb_rst_ni` low at any time, including mid-burst, immediately forces:
  - IDLE, with `grant_o` and all `wbs_*_o` = 0;
  - `last` = `NM-1`;
  - the watchdog counter cleared.

## Timing
- Arbitration latency: request `cyc` high in cycle n gives `grant_o` and `wbs_cyc_o` high in cycle n+1. Slave signals are combinational from the owner after that.
- The response path (slave → master) is purely combinational; no added latency.
- Release: owner drops `cyc` in cycle n. `wbs_cyc_o` is low in cycle n, because it follows the owner combinationally. `grant_o` clears at edge n+1. The earliest new grant is at edge n+2.
- Fairness: with all masters requesting continuously and each cycle lasting one access, grants rotate 0→1→2→0…

## Configuration
- Macro: `WB_ARB_WATCHDOG_EN`.
- Defined: a 16-bit counter increments every BUSY cycle in which `wbs_stb_o` is high and `wbs_ack_i|wbs_err_i|wbs_rty_i` is low. It clears on any termination, on leaving BUSY, and on reset.
- When the counter equals `TIMEOUT`, in that same cycle:
  - `wbm_err_o[g]` = 1 and `wbm_ack_o[g]` = 0;
  - `wbs_stb_o` and `wbs_cyc_o` are forced to 0;
  - the counter clears at the next edge.
- A slave ack arriving in the same cycle as the timeout is ignored; err wins.
- Not defined: no counter, no forced err; `TIMEOUT` has no effect.

## Test plan
- Reset: hold `wb_rst_ni`=0 with all `cyc` high → `grant_o`=0, `wbs_cyc_o`=0, all terminations 0. Release reset → `grant_o`=3'b001 one cycle later.
- Single master: master 2 reads address 0x100 and the slave acks with 0xDEADBEEF → `wbs_adr_o`=0x100, `wbm_ack_o`=3'b100, `wbm_dat_o`=0xDEADBEEF; `grant_o` clears one cycle after `cyc[2]` falls.
- Round-robin: all three masters request continuously, each doing a single acked access → owners in order 0,1,2,0, with exactly one IDLE cycle between consecutive owners.
- Burst lock: master 1 runs a 4-beat incrementing burst (`cti`=3'b010…3'b111, `bte`=0) while master 0 requests → master 0 receives no ack until master 1 drops `cyc`; all 4 acks are routed only to master 1.
- Mid-burst reset: assert `wb_rst_ni`=0 on beat 2 of a burst → `wbs_cyc_o`=0 asynchronously; after release, master 0 wins first.
- Watchdog (macro on, `TIMEOUT`=8): slave never acks → `wbm_err_o[g]`=1 with `wbs_cyc_o`=0 in the cycle the counter reaches 8. With the macro off, the same stimulus stalls indefinitely with no err.
